// File: rtl/player_bullet.sv
// Player laser shot: arms on fire, spawns at the muzzle on a frame tick, climbs until hit/off-screen, then cools down.
// Optional build macro BULLET_AUTOFIRE_EN makes the fire request level-sensitive (hold to re-fire).
module player_bullet #(
    parameter int BULLET_STEP     = 4,
    parameter int GUN_OFFSET_X    = 15,
    parameter int BULLET_H        = 8,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame,
    input  logic       fire,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic       hit,
    output logic [9:0] bullet_x,
    output logic [9:0] bullet_y,
    output logic       bullet_active,
    output logic       shot_fired
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FLY  = 2'd1;
    localparam logic [1:0] S_COOL = 2'd2;

    localparam logic [9:0] STEP    = 10'(BULLET_STEP);
    localparam logic [9:0] OFS_X   = 10'(GUN_OFFSET_X);
    localparam logic [9:0] HEIGHT  = 10'(BULLET_H);
    localparam logic [9:0] CD_INIT = 10'(COOLDOWN_FRAMES);

    logic [1:0] state;
    logic       fire_q;
    logic       pending;
    logic [9:0] cd_cnt;
    logic       fire_req;
    logic       retire;

`ifdef BULLET_AUTOFIRE_EN
    assign fire_req = fire;
`else
    assign fire_req = fire & ~fire_q;
`endif

    // hit outranks the off-the-top check; both leave bullet_y where it is
    assign retire = hit | (frame & (bullet_y < STEP));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            fire_q        <= 1'b0;
            pending       <= 1'b0;
            cd_cnt        <= '0;
            bullet_x      <= '0;
            bullet_y      <= '0;
            bullet_active <= 1'b0;
            shot_fired    <= 1'b0;
        end else begin
            fire_q     <= fire;
            shot_fired <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame && (pending || fire_req)) begin
                        bullet_x      <= player_x + OFS_X;
                        bullet_y      <= player_y - HEIGHT;
                        bullet_active <= 1'b1;
                        shot_fired    <= 1'b1;
                        pending       <= 1'b0;
                        state         <= S_FLY;
                    end else if (fire_req) begin
                        pending <= 1'b1;
                    end
                end
                S_FLY: begin
                    if (retire) begin
                        bullet_active <= 1'b0;
                        cd_cnt        <= CD_INIT;
                        state         <= (CD_INIT == '0) ? S_IDLE : S_COOL;
                    end else if (frame) begin
                        bullet_y <= bullet_y - STEP;
                    end
                end
                S_COOL: begin
                    if (frame) begin
                        cd_cnt <= cd_cnt - 10'd1;
                        if (cd_cnt <= 10'd1) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_player_bullet.sv
// Scoreboard bench for player_bullet: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_player_bullet;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame = 1'b0;
    logic       fire = 1'b0;
    logic [9:0] player_x = '0;
    logic [9:0] player_y = '0;
    logic       hit = 1'b0;
    logic [9:0] bullet_x, bullet_y;
    logic       bullet_active, shot_fired;

    player_bullet dut (
        .clk(clk), .rst(rst), .frame(frame), .fire(fire),
        .player_x(player_x), .player_y(player_y), .hit(hit),
        .bullet_x(bullet_x), .bullet_y(bullet_y),
        .bullet_active(bullet_active), .shot_fired(shot_fired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        string name;
        int    kind;   // 0: outputs, 1: total shot_fired count (in x)
        int    x;
        int    y;
        int    act;
        int    shot;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int shots = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation due at the edge just taken
    always @(negedge clk) begin
        if (shot_fired === 1'b1) shots = shots + 1;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks = checks + 1;
            if (e.cyc < cyc) begin
                errors = errors + 1;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if (e.kind == 1) begin
                if (shots != e.x) begin
                    errors = errors + 1;
                    $display("FAIL %s: shot count got %0d want %0d", e.name, shots, e.x);
                end
            end else if (bullet_x !== 10'(e.x) || bullet_y !== 10'(e.y) ||
                         bullet_active !== 1'(e.act) || shot_fired !== 1'(e.shot)) begin
                errors = errors + 1;
                $display("FAIL %s @%0d: got x=%0d y=%0d act=%b shot=%b want x=%0d y=%0d act=%0d shot=%0d",
                         e.name, cyc, bullet_x, bullet_y, bullet_active, shot_fired,
                         e.x, e.y, e.act, e.shot);
            end
        end
    end

    task automatic expect_out(input string nm, input int x, input int y, input int act, input int shot);
        exp_t e;
        e.cyc = cyc + 1; e.name = nm; e.kind = 0;
        e.x = x; e.y = y; e.act = act; e.shot = shot;
        q.push_back(e);
    endtask

    task automatic expect_shots(input string nm, input int n);
        exp_t e;
        e.cyc = cyc + 1; e.name = nm; e.kind = 1;
        e.x = n; e.y = 0; e.act = 0; e.shot = 0;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // one frame pulse followed by one quiet cycle, no output checks
    task automatic frame_pair();
        frame = 1'b1; tick();
        frame = 1'b0; tick();
    endtask

    initial begin
        int y;
        int want_shots;
        #2;
        // reset with a fire press that must not be remembered
        rst = 1'b0; fire = 1'b1;
        expect_out("reset0", 0, 0, 0, 0); tick();
        expect_out("reset1", 0, 0, 0, 0); tick();
        rst = 1'b1; fire = 1'b0;
        expect_out("post_reset", 0, 0, 0, 0); tick();
        frame = 1'b1;
        expect_out("no_pending_after_reset", 0, 0, 0, 0); tick();
        frame = 1'b0;

        // basic spawn
        player_x = 10'd100; player_y = 10'd440;
        fire = 1'b1; expect_out("armed_no_spawn", 0, 0, 0, 0); tick();
        fire = 1'b0; expect_out("idle_wait", 0, 0, 0, 0); tick();
        frame = 1'b1; expect_out("spawn", 115, 432, 1, 1); tick();
        frame = 1'b0; expect_out("shot_one_cycle", 115, 432, 1, 0); tick();

        // flight: player moves and fire is pressed, neither affects the bullet
        player_x = 10'd300;
        y = 432;
        for (int k = 0; k < 10; k++) begin
            y = y - 4;
            frame = 1'b1; fire = (k == 3);
            expect_out("fly_step", 115, y, 1, 0); tick();
            frame = 1'b0; fire = 1'b0;
            expect_out("fly_hold", 115, y, 1, 0); tick();
        end
        hit = 1'b1; frame = 1'b1;
        expect_out("hit_wins", 115, 392, 0, 0); tick();
        hit = 1'b0; frame = 1'b0;
        // cooldown, fire press in the middle is discarded
        for (int k = 0; k < 8; k++) begin
            frame = 1'b1; hit = (k == 2); fire = (k == 4);
            expect_out("cooldown", 115, 392, 0, 0); tick();
            frame = 1'b0; hit = 1'b0; fire = 1'b0; tick();
        end
        frame = 1'b1; expect_out("cd_fire_ignored", 115, 392, 0, 0); tick();
        frame = 1'b0; tick();

        // top-edge retirement
        player_x = 10'd200; player_y = 10'd14;
        fire = 1'b1; tick();
        fire = 1'b0; tick();
        frame = 1'b1; expect_out("spawn_y6", 215, 6, 1, 1); tick();
        frame = 1'b0; tick();
        frame = 1'b1; expect_out("y6_to_2", 215, 2, 1, 0); tick();
        frame = 1'b0; tick();
        frame = 1'b1; expect_out("retire_top", 215, 2, 0, 0); tick();
        frame = 1'b0; tick();
        for (int k = 0; k < 8; k++) begin
            fire = (k == 3); frame_pair(); fire = 1'b0;
        end
        player_y = 10'd440;
        frame = 1'b1; expect_out("no_shot_after_cd", 215, 2, 0, 0); tick();
        frame = 1'b0; tick();
        // fire edge in the same cycle as frame spawns at once
        fire = 1'b1; frame = 1'b1;
        expect_out("same_cycle_spawn", 215, 432, 1, 1); tick();
        fire = 1'b0; frame = 1'b0; tick();
        frame = 1'b1; expect_out("fly_before_reset", 215, 428, 1, 0); tick();
        frame = 1'b0;

        // reset mid-flight, fire edge during reset forgotten
        rst = 1'b0; fire = 1'b1;
        expect_out("reset_midflight", 0, 0, 0, 0); tick();
        rst = 1'b1; fire = 1'b0;
        expect_out("after_reset", 0, 0, 0, 0); tick();
        frame = 1'b1; expect_out("reset_edge_forgotten", 0, 0, 0, 0); tick();
        frame = 1'b0; tick();
        expect_shots("shots_before_hold", 3); tick();

        // hold fire across two cooldowns
        player_x = 10'd100;
        fire = 1'b1; tick();
        frame = 1'b1; expect_out("hold_spawn", 115, 432, 1, 1); tick();
        frame = 1'b0; tick();
        for (int r = 0; r < 2; r++) begin
            hit = 1'b1; tick();
            hit = 1'b0;
            for (int k = 0; k < 8; k++) frame_pair();
            frame_pair();
        end
`ifdef BULLET_AUTOFIRE_EN
        want_shots = 6;
`else
        want_shots = 4;
`endif
        expect_shots("hold_fire_shots", want_shots); tick();
        fire = 1'b0;

        for (int k = 0; k < 10 && q.size() > 0; k++) tick();
        if (q.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations never checked", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
